// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-side memory controller and its store buffer.
package data_mem_ctrl_pkg;

    localparam int SB_DEPTH = 4;
    localparam int OFFSET_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_ctrl_store_buffer.sv
// Circular store buffer holding posted stores as {word tag, data}, with a
// combinational youngest-match search used for load forwarding.
module data_mem_ctrl_store_buffer
    import data_mem_ctrl_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 30,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [W-1:0]     lookup_data,
    output logic [TAG_W-1:0] head_tag,
    output logic [W-1:0]     head_data,
    output logic             not_full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [W-1:0]     data_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] scan_idx;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered count, so a same-edge pop never frees a slot early.
    assign not_full  = count_q < CNT_W'(DEPTH);
    assign empty     = (count_q == '0);
    assign do_push   = push & not_full;
    assign do_pop    = pop & ~empty;
    assign head_tag  = tag_q[head_q];
    assign head_data = data_q[head_q];

    always_comb begin
        head_d  = head_q + PTR_W'(do_pop);
        tail_d  = tail_q + PTR_W'(do_push);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; validity is tracked by count_q alone,
    // which keeps the storage as plain registers without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_q[tail_q]  <= push_tag;
            data_q[tail_q] <= push_data;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (tag_q[scan_idx] == lookup_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[scan_idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: posts stores into a buffer, forwards loads from it,
// and arbitrates a single-port req/ack memory with loads ahead of drains.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int W      = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] l_addr,
    output logic [W-1:0]      l_data,
    output logic              l_valid,
    output logic              l_busy,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [W-1:0]      s_data,
    output logic              s_ready,
    output logic              sb_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_wdata,
    input  logic              mem_ack,
    input  logic [W-1:0]      mem_rdata
);

    localparam int TAG_W = ADDR_W - OFFSET_W;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [W-1:0]      l_data_q, l_data_d;
    logic              l_valid_q, l_valid_d;
    logic              l_busy_q, l_busy_d;
    logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;

    logic              sb_hit;
    logic [W-1:0]      sb_hit_data;
    logic [TAG_W-1:0]  head_tag;
    logic [W-1:0]      head_data;
    logic              buf_empty;
    logic              load_take;
    logic              drain_done;
    logic [TAG_W-1:0]  l_tag;
    logic              unused_addr_bits;

    assign l_tag            = l_addr[ADDR_W-1:OFFSET_W];
    assign load_take        = load_en & ~l_busy_q;
    assign drain_done       = (state_q == ST_WR) & mem_ack;
    assign unused_addr_bits = ^{l_addr[OFFSET_W-1:0], s_addr[OFFSET_W-1:0]};

    data_mem_ctrl_store_buffer #(
        .W     (W),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (store_en),
        .push_tag    (s_addr[ADDR_W-1:OFFSET_W]),
        .push_data   (s_data),
        .pop         (drain_done),
        .lookup_tag  (l_tag),
        .lookup_hit  (sb_hit),
        .lookup_data (sb_hit_data),
        .head_tag    (head_tag),
        .head_data   (head_data),
        .not_full    (s_ready),
        .empty       (buf_empty)
    );

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        l_data_d    = l_data_q;
        l_valid_d   = 1'b0;
        l_busy_d    = l_busy_q;
        pend_tag_d  = pend_tag_q;

        if (load_take && sb_hit && state_q != ST_RD) begin
            l_data_d  = sb_hit_data;
            l_valid_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load_take) begin
                    if (!sb_hit) begin
                        state_d    = ST_RD;
                        l_busy_d   = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {l_tag, OFFSET_W'(0)};
                    end
                end else if (!buf_empty) begin
                    state_d     = ST_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {head_tag, OFFSET_W'(0)};
                    mem_wdata_d = head_data;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    l_data_d  = mem_rdata;
                    l_valid_d = 1'b1;
                    l_busy_d  = 1'b0;
                end
            end
            ST_WR: begin
                // A busy load in WR is the miss waiting for this write to finish.
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    if (l_busy_q) begin
                        state_d    = ST_RD;
                        mem_addr_d = {pend_tag_q, OFFSET_W'(0)};
                    end else if (load_take && !sb_hit) begin
                        state_d    = ST_RD;
                        l_busy_d   = 1'b1;
                        mem_addr_d = {l_tag, OFFSET_W'(0)};
                    end else begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (load_take && !sb_hit) begin
                    l_busy_d   = 1'b1;
                    pend_tag_d = l_tag;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            l_data_q    <= '0;
            l_valid_q   <= 1'b0;
            l_busy_q    <= 1'b0;
            pend_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            l_data_q    <= l_data_d;
            l_valid_q   <= l_valid_d;
            l_busy_q    <= l_busy_d;
            pend_tag_q  <= pend_tag_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign l_data    = l_data_q;
    assign l_valid   = l_valid_q;
    assign l_busy    = l_busy_q;
    assign sb_empty  = buf_empty & (state_q != ST_WR);

endmodule
